// File: rtl/gpgpu_rf_pkg.sv
// Shared constants and helpers for the operand register-file bank arbiter.
// Slot IDs are {OCID[1:0], src_sel}; bank IDs select one of the RF banks.
package gpgpu_rf_pkg;

    localparam int NUM_BANK = 4;
    localparam int NUM_REQ  = 8;
    localparam int ROW_W    = 3;
    localparam int DATA_W   = 256;
    localparam int SLOT_W   = 3;
    localparam int BANK_W   = 2;
    localparam int CNT_W    = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

    // One-hot bank select used for the write-enable vector.
    function automatic logic [NUM_BANK-1:0] bank_onehot(input logic [BANK_W-1:0] bank);
        logic [NUM_BANK-1:0] oh;
        oh       = {NUM_BANK{1'b0}};
        oh[bank] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// 8-way round-robin arbiter for one RF bank. The search starts at the
// registered pointer, which moves just past the most recent winner.
module rr_arbiter
    import gpgpu_rf_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SLOT_W-1:0]  idx_o,
    output logic               valid_o
);

    logic [SLOT_W-1:0] ptr_q;
    logic [SLOT_W-1:0] ptr_d;
    logic [SLOT_W-1:0] cand_s;

    // Winner search: walking offsets downward leaves the closest requester to ptr as the winner.
    always_comb begin
        gnt_o   = {NUM_REQ{1'b0}};
        idx_o   = {SLOT_W{1'b0}};
        valid_o = 1'b0;
        ptr_d   = ptr_q;
        cand_s  = {SLOT_W{1'b0}};
        if (en_i) begin
            for (int off = NUM_REQ - 1; off >= 0; off--) begin
                cand_s = ptr_q + SLOT_W'(off);
                if (req_i[cand_s]) begin
                    idx_o   = cand_s;
                    valid_o = 1'b1;
                end else begin
                    idx_o   = idx_o;
                end
            end
            if (valid_o) begin
                gnt_o[idx_o] = 1'b1;
                ptr_d        = idx_o + 3'd1;
            end else begin
                ptr_d = ptr_q;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= {SLOT_W{1'b0}};
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_bank_arbiter.sv
// Read/write port arbiter for the banked operand register file: per-bank
// round-robin read grants, writeback priority, and slot tags aligned to RF data.
module rf_bank_arbiter
    import gpgpu_rf_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [BANK_W*NUM_REQ-1:0]  req_bank,
    input  logic [ROW_W*NUM_REQ-1:0]   req_row,
    output logic [NUM_REQ-1:0]         req_grant,
    input  logic                       wr_valid,
    input  logic [BANK_W-1:0]          wr_bank,
    input  logic [ROW_W-1:0]           wr_row,
    input  logic [DATA_W-1:0]          wr_data,
    output logic [NUM_BANK-1:0]        bank_rd_en,
    output logic [ROW_W*NUM_BANK-1:0]  bank_rd_row,
    output logic [NUM_BANK-1:0]        bank_wr_en,
    output logic [ROW_W-1:0]           bank_wr_row,
    output logic [DATA_W-1:0]          bank_wr_data,
    output logic [NUM_BANK-1:0]        rsp_valid,
    output logic [SLOT_W*NUM_BANK-1:0] rsp_tag,
    output logic [CNT_W-1:0]           conflict_cnt
);

    logic [NUM_REQ-1:0]         cand_s [NUM_BANK];
    logic [NUM_REQ-1:0]         gnt_s  [NUM_BANK];
    logic [SLOT_W-1:0]          gidx_s [NUM_BANK];
    logic [NUM_BANK-1:0]        en_s;
    logic [NUM_BANK-1:0]        gvalid_s;
    logic [NUM_REQ-1:0]         grant_any_s;
    logic                       conflict_s;
    logic [ROW_W*NUM_BANK-1:0]  rd_row_d;
    logic [SLOT_W*NUM_BANK-1:0] tag_d;
    logic [NUM_BANK-1:0]        wr_en_d;
    logic [CNT_W-1:0]           cnt_d;

    logic [NUM_BANK-1:0]        rd_en_q;
    logic [ROW_W*NUM_BANK-1:0]  rd_row_q;
    logic [SLOT_W*NUM_BANK-1:0] tag1_q;
    logic [NUM_BANK-1:0]        wr_en_q;
    logic [ROW_W-1:0]           wr_row_q;
    logic [DATA_W-1:0]          wr_data_q;
    logic [NUM_BANK-1:0]        rsp_valid_q;
    logic [SLOT_W*NUM_BANK-1:0] rsp_tag_q;
    logic [CNT_W-1:0]           cnt_q;

    // Candidate decode per bank; a writeback to a bank blocks its read grant.
    always_comb begin
        for (int b = 0; b < NUM_BANK; b++) begin
            en_s[b] = !(wr_valid && (wr_bank == BANK_W'(b)));
            for (int i = 0; i < NUM_REQ; i++) begin
                cand_s[b][i] = req_valid[i] && (req_bank[BANK_W*i +: BANK_W] == BANK_W'(b));
            end
        end
    end

    for (genvar gb = 0; gb < NUM_BANK; gb++) begin : g_bank
        rr_arbiter u_rr (
            .clk     (clk),
            .rst     (rst),
            .req_i   (cand_s[gb]),
            .en_i    (en_s[gb]),
            .gnt_o   (gnt_s[gb]),
            .idx_o   (gidx_s[gb]),
            .valid_o (gvalid_s[gb])
        );
    end

    // Merge bank grants into the slot view and pick the granted row/tag per bank.
    always_comb begin
        grant_any_s = {NUM_REQ{1'b0}};
        rd_row_d    = {(ROW_W*NUM_BANK){1'b0}};
        tag_d       = {(SLOT_W*NUM_BANK){1'b0}};
        for (int b = 0; b < NUM_BANK; b++) begin
            grant_any_s = grant_any_s | gnt_s[b];
            tag_d[SLOT_W*b +: SLOT_W] = gidx_s[b];
            if (gvalid_s[b]) begin
                rd_row_d[ROW_W*b +: ROW_W] = req_row[ROW_W*gidx_s[b] +: ROW_W];
            end else begin
                rd_row_d[ROW_W*b +: ROW_W] = {ROW_W{1'b0}};
            end
        end
    end

    assign req_grant  = rst ? grant_any_s : {NUM_REQ{1'b0}};
    assign conflict_s = |(req_valid & ~req_grant);

    // Write-enable decode and saturating conflict counter next state.
    always_comb begin
        wr_en_d = {NUM_BANK{1'b0}};
        cnt_d   = cnt_q;
        if (wr_valid) begin
            wr_en_d = bank_onehot(wr_bank);
        end else begin
            wr_en_d = {NUM_BANK{1'b0}};
        end
        if (conflict_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage 1: bank command registers (read and write issue).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_en_q   <= {NUM_BANK{1'b0}};
            rd_row_q  <= {(ROW_W*NUM_BANK){1'b0}};
            tag1_q    <= {(SLOT_W*NUM_BANK){1'b0}};
            wr_en_q   <= {NUM_BANK{1'b0}};
            wr_row_q  <= {ROW_W{1'b0}};
            wr_data_q <= {DATA_W{1'b0}};
        end else begin
            rd_en_q  <= gvalid_s;
            rd_row_q <= rd_row_d;
            tag1_q   <= tag_d;
            wr_en_q  <= wr_en_d;
            if (wr_valid) begin
                wr_row_q  <= wr_row;
                wr_data_q <= wr_data;
            end else begin
                wr_row_q  <= wr_row_q;
                wr_data_q <= wr_data_q;
            end
        end
    end

    // Stage 2: tags delayed to line up with the one-cycle RF read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= {NUM_BANK{1'b0}};
            rsp_tag_q   <= {(SLOT_W*NUM_BANK){1'b0}};
        end else begin
            rsp_valid_q <= rd_en_q;
            rsp_tag_q   <= tag1_q;
        end
    end

    // Conflict counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bank_rd_en   = rd_en_q;
    assign bank_rd_row  = rd_row_q;
    assign bank_wr_en   = wr_en_q;
    assign bank_wr_row  = wr_row_q;
    assign bank_wr_data = wr_data_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_tag      = rsp_tag_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Self-checking bench for rf_bank_arbiter: directed scenarios plus random
// traffic compared against a slot/bank level reference model.
module tb_rf_bank_arbiter;

    logic         clk;
    logic         rst;
    logic [7:0]   req_valid;
    logic [15:0]  req_bank;
    logic [23:0]  req_row;
    logic [7:0]   req_grant;
    logic         wr_valid;
    logic [1:0]   wr_bank;
    logic [2:0]   wr_row;
    logic [255:0] wr_data;
    logic [3:0]   bank_rd_en;
    logic [11:0]  bank_rd_row;
    logic [3:0]   bank_wr_en;
    logic [2:0]   bank_wr_row;
    logic [255:0] bank_wr_data;
    logic [3:0]   rsp_valid;
    logic [11:0]  rsp_tag;
    logic [15:0]  conflict_cnt;

    rf_bank_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_bank     (req_bank),
        .req_row      (req_row),
        .req_grant    (req_grant),
        .wr_valid     (wr_valid),
        .wr_bank      (wr_bank),
        .wr_row       (wr_row),
        .wr_data      (wr_data),
        .bank_rd_en   (bank_rd_en),
        .bank_rd_row  (bank_rd_row),
        .bank_wr_en   (bank_wr_en),
        .bank_wr_row  (bank_wr_row),
        .bank_wr_data (bank_wr_data),
        .rsp_valid    (rsp_valid),
        .rsp_tag      (rsp_tag),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Pending requests held by each slot.
    bit       sv [8];
    int       sb [8];
    int       sr [8];
    // Reference model state.
    int       ptr [4];
    int       cnt;
    bit       s1_rd [4];
    int       s1_row [4];
    int       s1_tag [4];
    bit       s2_rd [4];
    int       s2_tag [4];
    int       s1_wr_bank;
    bit       s1_wr;
    int       s1_wr_row;
    logic [255:0] s1_wr_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            req_valid[i]       = sv[i];
            req_bank[2*i +: 2] = 2'(sb[i]);
            req_row[3*i +: 3]  = 3'(sr[i]);
        end
    endtask

    task automatic model_reset();
        cnt   = 0;
        s1_wr = 1'b0;
        for (int b = 0; b < 4; b++) begin
            ptr[b] = 0; s1_rd[b] = 1'b0; s2_rd[b] = 1'b0;
        end
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic cycle();
        logic [7:0] g;
        bit  ng_rd [4];
        int  ng_row [4];
        int  ng_tag [4];
        bit  conflict;
        drive();
        #2;
        g = 8'h00;
        for (int b = 0; b < 4; b++) begin
            ng_rd[b] = 1'b0; ng_row[b] = 0; ng_tag[b] = 0;
            if (!(wr_valid && (int'(wr_bank) == b))) begin
                for (int k = 0; k < 8; k++) begin
                    int s;
                    s = (ptr[b] + k) % 8;
                    if (!ng_rd[b] && sv[s] && sb[s] == b) begin
                        ng_rd[b] = 1'b1; ng_row[b] = sr[s]; ng_tag[b] = s;
                        g[s] = 1'b1;
                    end
                end
                if (ng_rd[b]) ptr[b] = (ng_tag[b] + 1) % 8;
            end
        end
        chk("req_grant", req_grant, g);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("rd_en[%0d]", b), bank_rd_en[b], s1_rd[b]);
            if (s1_rd[b]) chk($sformatf("rd_row[%0d]", b), bank_rd_row[3*b +: 3], s1_row[b]);
            chk($sformatf("rsp_valid[%0d]", b), rsp_valid[b], s2_rd[b]);
            if (s2_rd[b]) chk($sformatf("rsp_tag[%0d]", b), rsp_tag[3*b +: 3], s2_tag[b]);
        end
        chk("wr_en", bank_wr_en, s1_wr ? (4'b0001 << s1_wr_bank) : 4'b0000);
        if (s1_wr) begin
            chk("wr_row", bank_wr_row, s1_wr_row);
            chk("wr_data", bank_wr_data, s1_wr_data);
        end
        chk("conflict_cnt", conflict_cnt, cnt);
        conflict = 1'b0;
        for (int i = 0; i < 8; i++) if (sv[i] && !g[i]) conflict = 1'b1;
        if (conflict && cnt < 65535) cnt++;
        for (int b = 0; b < 4; b++) begin
            s2_rd[b] = s1_rd[b]; s2_tag[b] = s1_tag[b];
            s1_rd[b] = ng_rd[b]; s1_row[b] = ng_row[b]; s1_tag[b] = ng_tag[b];
        end
        s1_wr = wr_valid; s1_wr_bank = int'(wr_bank); s1_wr_row = int'(wr_row); s1_wr_data = wr_data;
        for (int i = 0; i < 8; i++) if (g[i]) sv[i] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse starting at posedge+1; checks cleared outputs.
    task automatic do_reset();
        drive();
        rst = 1'b0;
        #1;
        chk("rst_grant", req_grant, 8'h00);
        chk("rst_rd_en", bank_rd_en, 4'h0);
        chk("rst_rd_row", bank_rd_row, 12'h000);
        chk("rst_wr_en", bank_wr_en, 4'h0);
        chk("rst_wr_row", bank_wr_row, 3'h0);
        chk("rst_wr_data", bank_wr_data, 256'h0);
        chk("rst_rsp_valid", rsp_valid, 4'h0);
        chk("rst_rsp_tag", rsp_tag, 12'h000);
        chk("rst_cnt", conflict_cnt, 16'h0000);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic clear_slots();
        for (int i = 0; i < 8; i++) begin
            sv[i] = 1'b0; sb[i] = 0; sr[i] = 0;
        end
    endtask

    task automatic set_slot(input int s, input int b, input int r);
        sv[s] = 1'b1; sb[s] = b; sr[s] = r;
    endtask

    initial begin
        rst = 1'b0;
        wr_valid = 1'b0; wr_bank = 2'd0; wr_row = 3'd0; wr_data = 256'h0;
        clear_slots();
        model_reset();
        drive();
        @(posedge clk);
        #1;

        // Slot 0 -> bank 2 row 5, requested while in reset and right after release.
        set_slot(0, 2, 5);
        do_reset();
        repeat (3) cycle();

        // Slots 1, 3, 6 contend for bank 0, then 0 and 7 probe ptr[0]=7.
        set_slot(1, 0, 1); set_slot(3, 0, 3); set_slot(6, 0, 6);
        repeat (3) cycle();
        chk("cnt_after_rr", conflict_cnt, 16'd2);
        set_slot(0, 0, 2); set_slot(7, 0, 4);
        repeat (4) cycle();

        // Write to bank 1 row 2 blocks slot 4's read for one cycle.
        set_slot(4, 1, 2);
        wr_valid = 1'b1; wr_bank = 2'd1; wr_row = 3'd2; wr_data = {8{32'hA5A5_0001}};
        cycle();
        wr_valid = 1'b0;
        repeat (3) cycle();

        // Bring ptr[3] to 7, then all eight slots in bank pairs.
        set_slot(6, 3, 1);
        repeat (2) cycle();
        set_slot(0, 3, 0); set_slot(1, 3, 1); set_slot(2, 0, 2); set_slot(3, 0, 3);
        set_slot(4, 1, 4); set_slot(5, 1, 5); set_slot(6, 2, 6); set_slot(7, 2, 7);
        repeat (4) cycle();

        // Reset between grant and response.
        set_slot(2, 1, 3);
        cycle();
        do_reset();
        repeat (3) cycle();

        // Random traffic with occasional writes and resets.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (!sv[i] && $urandom_range(0, 99) < 60)
                    set_slot(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            end
            wr_valid = ($urandom_range(0, 99) < 40);
            wr_bank  = 2'($urandom_range(0, 3));
            wr_row   = 3'($urandom_range(0, 7));
            wr_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom()};
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        // Starve slot 5 behind a permanent bank-0 write to saturate the counter.
        wr_valid = 1'b0;
        clear_slots();
        repeat (2) cycle();
        set_slot(5, 0, 3);
        wr_valid = 1'b1; wr_bank = 2'd0; wr_row = 3'd1; wr_data = {8{32'h0BAD_F00D}};
        for (int n = 0; n < 70000; n++) cycle();
        chk("cnt_saturated", conflict_cnt, 16'hFFFF);
        wr_valid = 1'b0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
